// File: rtl/audio_sfx_scheduler.sv
// Plays one of four 1-bit sound effects from a shared sample ROM, chosen by fixed priority
// from latched requests, with samples paced by an internal sample-rate divider.
module audio_sfx_scheduler #(
    parameter logic [15:0] CLK_DIV    = 16'd2500,
    parameter logic [63:0] BASE_TABLE = 64'h0300_0200_0100_0000,
    parameter logic [63:0] LEN_TABLE  = 64'h0,
    parameter logic        PREEMPT    = 1'b1
) (
    input  logic        Master_Clock_In,
    input  logic        Master_Reset_N_In,
    input  logic [3:0]  Sfx_Req_In,
    input  logic        Sfx_Stop_In,
    input  logic        Enable_In,
    output logic [15:0] Rom_Addr_Out,
    output logic        Rom_Rd_Out,
    input  logic        Rom_Data_In,
    output logic        Signal,
    output logic        Busy_Out,
    output logic [1:0]  Active_Sfx_Out,
    output logic [3:0]  Pending_Out,
    output logic        Done_Pulse_Out
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        PLAY  = 3'd3,
        TAIL  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  pending_q, pending_d;
    logic [15:0] div_q, div_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] remain_q, remain_d;
    logic [1:0]  active_q, active_d;
    logic        sample_q, sample_d;
    logic        signal_q, signal_d;
    logic        done_q, done_d;
    logic        rd_q, rd_d;
    logic        busy_q, busy_d;

    logic [15:0] base_arr [4];
    logic [15:0] len_arr  [4];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_table
            assign base_arr[gi] = BASE_TABLE[16*gi +: 16];
            assign len_arr[gi]  = LEN_TABLE[16*gi +: 16];
        end
    endgenerate

    logic        req_any;
    logic [1:0]  req_idx;
    logic        tick;
    logic        grant;
    logic [15:0] remain_dec;

    always_comb begin
        req_any = |pending_q;
        req_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (pending_q[i]) req_idx = 2'(i);
        end
    end

    assign tick       = (div_q == CLK_DIV - 16'd1);
    assign remain_dec = remain_q - 16'd1;

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q | Sfx_Req_In;
        div_d     = div_q;
        addr_d    = addr_q;
        remain_d  = remain_q;
        active_d  = active_q;
        sample_d  = sample_q;
        signal_d  = signal_q;
        done_d    = 1'b0;
        grant     = 1'b0;

        if (state_q != IDLE) div_d = tick ? 16'd0 : div_q + 16'd1;

        // A lower index outranks the active effect; only that case may interrupt playback.
        if (Enable_In && req_any) begin
            if (state_q == IDLE)
                grant = 1'b1;
            else if (PREEMPT && (req_idx < active_q))
                grant = 1'b1;
        end

        if (Sfx_Stop_In) begin
            state_d   = IDLE;
            pending_d = 4'd0;
            signal_d  = 1'b0;
            active_d  = 2'd0;
        end else if (grant) begin
            pending_d[req_idx] = 1'b0;
            addr_d   = base_arr[req_idx];
            remain_d = len_arr[req_idx];
            div_d    = 16'd0;
            // An empty effect completes immediately without touching the ROM.
            if (len_arr[req_idx] == 16'd0) begin
                state_d  = IDLE;
                active_d = 2'd0;
                signal_d = 1'b0;
                done_d   = 1'b1;
            end else begin
                state_d  = FETCH;
                active_d = req_idx;
            end
        end else begin
            case (state_q)
                FETCH: state_d = WAIT;
                WAIT: begin
                    sample_d = Rom_Data_In;
                    state_d  = PLAY;
                end
                PLAY: begin
                    if (tick) begin
                        signal_d = sample_q;
                        addr_d   = addr_q + 16'd1;
                        remain_d = remain_dec;
                        state_d  = (remain_dec != 16'd0) ? FETCH : TAIL;
                    end
                end
                TAIL: begin
                    if (tick) begin
                        signal_d = 1'b0;
                        done_d   = 1'b1;
                        active_d = 2'd0;
                        state_d  = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        rd_d   = (state_d == FETCH);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge Master_Clock_In or negedge Master_Reset_N_In) begin
        if (!Master_Reset_N_In) begin
            state_q   <= IDLE;
            pending_q <= 4'd0;
            div_q     <= 16'd0;
            addr_q    <= 16'd0;
            remain_q  <= 16'd0;
            active_q  <= 2'd0;
            sample_q  <= 1'b0;
            signal_q  <= 1'b0;
            done_q    <= 1'b0;
            rd_q      <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            div_q     <= div_d;
            addr_q    <= addr_d;
            remain_q  <= remain_d;
            active_q  <= active_d;
            sample_q  <= sample_d;
            signal_q  <= signal_d;
            done_q    <= done_d;
            rd_q      <= rd_d;
            busy_q    <= busy_d;
        end
    end

    assign Rom_Addr_Out   = addr_q;
    assign Rom_Rd_Out     = rd_q;
    assign Signal         = signal_q;
    assign Busy_Out       = busy_q;
    assign Active_Sfx_Out = active_q;
    assign Pending_Out    = pending_q;
    assign Done_Pulse_Out = done_q;

endmodule

// File: tb/tb_audio_sfx_scheduler.sv
// Bench for audio_sfx_scheduler: three instances (default, no preemption, wrapping base)
// share stimulus; a timing-formula model is checked every cycle plus directed literals.
module tb_audio_sfx_scheduler;

    localparam int NI = 3;
    localparam int D  = 4;
    localparam logic [3*64-1:0] BASE_ALL = {64'h0300_0200_0100_FFFF,
                                            64'h0300_0200_0100_0000,
                                            64'h0300_0200_0100_0000};
    localparam logic [3*64-1:0] LEN_ALL  = {64'h0000_0005_0002_0002,
                                            64'h0000_0005_0002_0003,
                                            64'h0000_0005_0002_0003};
    localparam logic [NI-1:0] PRE_ALL = 3'b101;

    logic clk;
    logic rst_n;
    logic [3:0] req;
    logic stop;
    logic en;

    logic [NI*16-1:0] addr_o;
    logic [NI-1:0]    rd_o;
    logic [NI-1:0]    sig_o;
    logic [NI-1:0]    busy_o;
    logic [NI*2-1:0]  act_o;
    logic [NI*4-1:0]  pend_o;
    logic [NI-1:0]    done_o;

    int n_cmp = 0;
    int n_bad = 0;

    generate
        for (genvar gi = 0; gi < NI; gi++) begin : g_dut
            logic rom_data;
            audio_sfx_scheduler #(
                .CLK_DIV   (16'd4),
                .BASE_TABLE(BASE_ALL[64*gi +: 64]),
                .LEN_TABLE (LEN_ALL[64*gi +: 64]),
                .PREEMPT   (PRE_ALL[gi])
            ) u_dut (
                .Master_Clock_In  (clk),
                .Master_Reset_N_In(rst_n),
                .Sfx_Req_In       (req),
                .Sfx_Stop_In      (stop),
                .Enable_In        (en),
                .Rom_Addr_Out     (addr_o[16*gi +: 16]),
                .Rom_Rd_Out       (rd_o[gi]),
                .Rom_Data_In      (rom_data),
                .Signal           (sig_o[gi]),
                .Busy_Out         (busy_o[gi]),
                .Active_Sfx_Out   (act_o[2*gi +: 2]),
                .Pending_Out      (pend_o[4*gi +: 4]),
                .Done_Pulse_Out   (done_o[gi])
            );
            // ROM content is the low address bit, one cycle read latency
            always @(posedge clk) begin
                if (rd_o[gi]) rom_data <= addr_o[16*gi];
            end
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic       m_busy [NI];
    int         m_eff  [NI];
    int         m_cnt  [NI];
    logic [3:0] m_pend [NI];
    logic       m_sig  [NI];
    logic       m_done [NI];

    function automatic logic [15:0] tbase(input int n, input int i);
        return BASE_ALL[64*n + 16*i +: 16];
    endfunction

    function automatic int tlen(input int n, input int i);
        return int'(LEN_ALL[64*n + 16*i +: 16]);
    endfunction

    function automatic int lowest(input logic [3:0] p);
        int r;
        r = 4;
        for (int i = 3; i >= 0; i--) if (p[i]) r = i;
        return r;
    endfunction

    task automatic model_reset();
        for (int n = 0; n < NI; n++) begin
            m_busy[n] = 1'b0;
            m_eff[n]  = 0;
            m_cnt[n]  = 0;
            m_pend[n] = 4'd0;
            m_sig[n]  = 1'b0;
            m_done[n] = 1'b0;
        end
    endtask

    task automatic model_step();
        for (int n = 0; n < NI; n++) begin
            logic [3:0]  pin;
            logic [15:0] a;
            int g;
            int len;
            int k;
            pin = m_pend[n] | req;
            g = lowest(m_pend[n]);
            m_done[n] = 1'b0;
            if (stop) begin
                m_pend[n] = 4'd0;
                m_busy[n] = 1'b0;
                m_sig[n]  = 1'b0;
            end else if (en && m_pend[n] != 4'd0 &&
                         (!m_busy[n] || (PRE_ALL[n] && g < m_eff[n]))) begin
                pin[g] = 1'b0;
                m_pend[n] = pin;
                if (tlen(n, g) == 0) begin
                    m_busy[n] = 1'b0;
                    m_done[n] = 1'b1;
                    m_sig[n]  = 1'b0;
                end else begin
                    m_busy[n] = 1'b1;
                    m_eff[n]  = g;
                    m_cnt[n]  = 0;
                end
            end else begin
                m_pend[n] = pin;
                if (m_busy[n]) begin
                    m_cnt[n] = m_cnt[n] + 1;
                    len = tlen(n, m_eff[n]);
                    k = m_cnt[n] / D;
                    if (m_cnt[n] % D == 0) begin
                        if (k >= 1 && k <= len) begin
                            a = tbase(n, m_eff[n]) + 16'(k - 1);
                            m_sig[n] = a[0];
                        end else if (k == len + 1) begin
                            m_sig[n]  = 1'b0;
                            m_done[n] = 1'b1;
                            m_busy[n] = 1'b0;
                        end
                    end
                end
            end
        end
    endtask

    task automatic chk(input string name, input int n, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s inst%0d: got %0h expected %0h at %0t", name, n, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // every-cycle compare against the model
    initial begin
        forever begin
            @(negedge clk);
            for (int n = 0; n < NI; n++) begin
                logic exp_rd;
                logic [15:0] exp_addr;
                exp_rd = m_busy[n] && (m_cnt[n] % D == 0) && (m_cnt[n] / D < tlen(n, m_eff[n]));
                exp_addr = tbase(n, m_eff[n]) + 16'(m_cnt[n] / D);
                chk("busy", n, 32'(busy_o[n]), 32'(m_busy[n]));
                chk("active", n, 32'(act_o[2*n +: 2]), m_busy[n] ? 32'(m_eff[n]) : 32'd0);
                chk("pending", n, 32'(pend_o[4*n +: 4]), 32'(m_pend[n]));
                chk("signal", n, 32'(sig_o[n]), 32'(m_sig[n]));
                chk("done", n, 32'(done_o[n]), 32'(m_done[n]));
                chk("rom_rd", n, 32'(rd_o[n]), 32'(exp_rd));
                if (exp_rd) chk("rom_addr", n, 32'(addr_o[16*n +: 16]), 32'(exp_addr));
            end
        end
    end

    task automatic cyc(input int k);
        repeat (k) @(negedge clk);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        rst_n = 1'b0;
        req   = 4'd0;
        stop  = 1'b0;
        en    = 1'b1;
        model_reset();
        cyc(3);
        chk("rst_busy", 0, 32'(busy_o[0]), 32'd0);
        chk("rst_sig", 0, 32'(sig_o[0]), 32'd0);
        chk("rst_addr", 0, 32'(addr_o[15:0]), 32'd0);
        chk("rst_pend", 0, 32'(pend_o[3:0]), 32'd0);
        rst_n = 1'b1;
        cyc(2);

        // 1: effect1, two samples
        req = 4'b0010; cyc(1); req = 4'd0;
        chk("t1_pend", 0, 32'(pend_o[3:0]), 32'h2);
        cyc(1);
        chk("t1_act", 0, 32'(act_o[1:0]), 32'd1);
        chk("t1_addr0", 0, 32'(addr_o[15:0]), 32'h0100);
        chk("t1_rd0", 0, 32'(rd_o[0]), 32'd1);
        cyc(4);
        chk("t1_sig4", 0, 32'(sig_o[0]), 32'd0);
        chk("t1_addr1", 0, 32'(addr_o[15:0]), 32'h0101);
        cyc(4);
        chk("t1_sig8", 0, 32'(sig_o[0]), 32'd1);
        cyc(4);
        chk("t1_done", 0, 32'(done_o[0]), 32'd1);
        chk("t1_sig12", 0, 32'(sig_o[0]), 32'd0);
        cyc(1);
        chk("t1_busy13", 0, 32'(busy_o[0]), 32'd0);
        chk("t1_done13", 0, 32'(done_o[0]), 32'd0);
        cyc(3);

        // 2: two requests at once, effect1 then effect2
        req = 4'b0110; cyc(1); req = 4'd0;
        chk("t2_pend0", 0, 32'(pend_o[3:0]), 32'h6);
        cyc(1);
        chk("t2_pend1", 0, 32'(pend_o[3:0]), 32'h4);
        chk("t2_act1", 0, 32'(act_o[1:0]), 32'd1);
        cyc(12);
        chk("t2_done1", 0, 32'(done_o[0]), 32'd1);
        cyc(1);
        chk("t2_pend2", 0, 32'(pend_o[3:0]), 32'h0);
        chk("t2_act2", 0, 32'(act_o[1:0]), 32'd2);
        chk("t2_addr2", 0, 32'(addr_o[15:0]), 32'h0200);
        chk("t2_rd2", 0, 32'(rd_o[0]), 32'd1);

        // 3: preemption during effect2's second sample
        cyc(4);
        chk("t3_addr", 0, 32'(addr_o[15:0]), 32'h0201);
        req = 4'b0001; cyc(1); req = 4'd0;
        chk("t3_pend", 0, 32'(pend_o[3:0]), 32'h1);
        cyc(1);
        chk("t3_act0", 0, 32'(act_o[1:0]), 32'd0);
        chk("t3_addr0", 0, 32'(addr_o[15:0]), 32'h0000);
        chk("t3_busy0", 0, 32'(busy_o[0]), 32'd1);
        chk("t3_np_act", 1, 32'(act_o[3:2]), 32'd2);
        chk("t3_np_pend", 1, 32'(pend_o[7:4]), 32'h1);
        chk("t5_addr_ffff", 2, 32'(addr_o[47:32]), 32'hFFFF);
        cyc(4);
        chk("t5_addr_wrap", 2, 32'(addr_o[47:32]), 32'h0000);
        chk("t5_sig", 2, 32'(sig_o[2]), 32'd1);
        cyc(14);
        chk("t3_np_done", 1, 32'(done_o[1]), 32'd1);
        cyc(1);
        chk("t3_np_act0", 1, 32'(act_o[3:2]), 32'd0);
        chk("t3_np_rd", 1, 32'(rd_o[1]), 32'd1);
        cyc(40);

        // 4: zero-length effect3
        req = 4'b1000; cyc(1); req = 4'd0;
        chk("t4_pend", 0, 32'(pend_o[3:0]), 32'h8);
        cyc(1);
        chk("t4_done", 0, 32'(done_o[0]), 32'd1);
        chk("t4_busy", 0, 32'(busy_o[0]), 32'd0);
        chk("t4_rd", 0, 32'(rd_o[0]), 32'd0);
        cyc(1);
        chk("t4_done_end", 0, 32'(done_o[0]), 32'd0);
        cyc(2);

        // 5: stop with a coincident request, mid-play
        req = 4'b0001; cyc(1); req = 4'd0;
        cyc(5);
        chk("t5_sig_before", 2, 32'(sig_o[2]), 32'd1);
        cyc(2);
        stop = 1'b1; req = 4'b0100; cyc(1); stop = 1'b0; req = 4'd0;
        for (int n = 0; n < NI; n++) begin
            chk("t5_busy", n, 32'(busy_o[n]), 32'd0);
            chk("t5_sig_stop", n, 32'(sig_o[n]), 32'd0);
            chk("t5_pend", n, 32'(pend_o[4*n +: 4]), 32'd0);
            chk("t5_nodone", n, 32'(done_o[n]), 32'd0);
        end
        cyc(3);

        // 6: asynchronous reset mid-play
        req = 4'b0100; cyc(1); req = 4'd0;
        cyc(10);
        chk("t6_sig_before", 0, 32'(sig_o[0]), 32'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int n = 0; n < NI; n++) begin
            chk("t6_busy", n, 32'(busy_o[n]), 32'd0);
            chk("t6_sig", n, 32'(sig_o[n]), 32'd0);
            chk("t6_act", n, 32'(act_o[2*n +: 2]), 32'd0);
            chk("t6_addr", n, 32'(addr_o[16*n +: 16]), 32'd0);
            chk("t6_rd", n, 32'(rd_o[n]), 32'd0);
        end
        cyc(3);
        rst_n = 1'b1;
        cyc(10);
        chk("t6_idle", 0, 32'(busy_o[0]), 32'd0);

        // Enable_In low holds off grants
        en = 1'b0;
        req = 4'b0010; cyc(1); req = 4'd0;
        cyc(5);
        chk("en_busy", 0, 32'(busy_o[0]), 32'd0);
        chk("en_pend", 0, 32'(pend_o[3:0]), 32'h2);
        en = 1'b1;
        cyc(1);
        chk("en_grant", 0, 32'(act_o[1:0]), 32'd1);
        chk("en_busy1", 0, 32'(busy_o[0]), 32'd1);
        cyc(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/audio_sfx_scheduler.md
Name: audio_sfx_scheduler

Overview:
Sequences playback of up to four sound effects stored back-to-back in one shared 1-bit sample ROM and drives the single audio output bit.
Latches play requests from game logic and grants the ROM/output to one effect at a time by fixed priority. Paces sample fetches with an internal sample-rate divider. Sits between game event logic and the sample ROM / audio output pin.

Parameters:
CLK_DIV, 16'd2500, clock cycles per output sample (25 MHz / 10 kHz); must be >= 4
BASE_TABLE, 64'h0300_0200_0100_0000, packed 4x16-bit ROM start address; effect i at bits [16i+15:16i]
LEN_TABLE, 64'h0, packed 4x16-bit sample count per effect; same packing as BASE_TABLE
PREEMPT, 1'b1, 1 = a higher-priority pending effect aborts the current one

Ports:
Master_Clock_In  in  1  system clock (25 MHz)
Master_Reset_N_In  in  1  asynchronous active-low reset
Sfx_Req_In  in  4  play request per effect; bit 0 highest priority
Sfx_Stop_In  in  1  abort playback and flush all pending requests
Enable_In  in  1  1 = new grants allowed
Rom_Addr_Out  out  16  sample ROM address
Rom_Rd_Out  out  1  ROM read strobe; data valid on Rom_Data_In one cycle later
Rom_Data_In  in  1  ROM sample bit
Signal  out  1  audio output bit
Busy_Out  out  1  high when the state is not IDLE
Active_Sfx_Out  out  2  index of the granted effect; 0 when idle
Pending_Out  out  4  latched pending requests
Done_Pulse_Out  out  1  one-cycle pulse on normal completion only

Behaviour:
- Reset (async, any state): state IDLE. All outputs, pending[3:0], divider, address and remaining-count registers = 0.
- Pending: pending[i] is set on every cycle Sfx_Req_In[i]=1. It is cleared on the cycle effect i is granted; the clear wins over a coincident request. All bits are cleared by Sfx_Stop_In, which also drops requests arriving in the same cycle.
- States: IDLE, FETCH, WAIT, PLAY, TAIL.
- IDLE: Signal=0. If Enable_In=1 and pending!=0, grant the lowest set index i.
  - Load addr=BASE[i], remaining=LEN[i], divider=0.
  - If LEN[i]=0: pulse Done next cycle, stay IDLE, no ROM read.
  - Otherwise go to FETCH.
- FETCH: Rom_Rd_Out=1 and Rom_Addr_Out=addr for exactly 1 cycle, then go to WAIT.
- WAIT: capture Rom_Data_In into sample_buf, then go to PLAY.
- PLAY: wait for tick. On tick: Signal<=sample_buf, addr<=addr+1 (16-bit wrap, 0xFFFF->0x0000), remaining<=remaining-1. Next state is FETCH if the new remaining is nonzero, else TAIL.
- TAIL: on tick, Signal<=0, Done_Pulse_Out=1 for one cycle, go to IDLE. Pending requests are granted from IDLE on the following cycle.
- Divider: counts 0..CLK_DIV-1 continuously in FETCH/WAIT/PLAY/TAIL. Tick occurs when divider=CLK_DIV-1, and the divider then returns to 0. It is only cleared on grant.
- Timing: with the grant at edge T, the first Signal update is at edge T+CLK_DIV and sample k updates at T+(k+1)*CLK_DIV. Done pulses at T+(LEN+1)*CLK_DIV, so every sample is held exactly CLK_DIV cycles.
- Preemption (PREEMPT=1, state not IDLE): if pending has a set bit with index < active, that effect is granted in the same cycle. Its address/length are loaded, divider=0, state goes to FETCH. Signal holds its value and no Done is pulsed. The aborted effect is not re-queued.
- Sfx_Stop_In=1 (any state): IDLE next cycle, Signal=0, pending=0, no Done. Stop beats preemption and grant in the same cycle.
- Enable_In=0: blocks grants and preemption only; the current effect plays to completion.
- Rom_Rd_Out is never asserted outside FETCH.

Test Plan:
All scenarios use CLK_DIV=4, BASE={0x0300,0x0200,0x0100,0x0000}, LEN={0,5,2,3} (effect3..0) and a 1-cycle-latency ROM model returning addr[0].

1. Pulse Sfx_Req_In=0b0010 at edge T -> ROM reads at 0x0100 and 0x0101. Signal=0 at T+4 and =1 at T+8, =0 at T+12. Done_Pulse_Out at T+12, Busy_Out low at T+13.
2. Sfx_Req_In=0b0110 in one cycle -> effect1 plays fully, then effect2 is granted on the cycle after effect1's Done with its first read at 0x0200. Pending_Out goes 0110 -> 0100 -> 0000.
3. Effect2 playing at its 2nd sample, pulse req bit0 -> next cycle Active_Sfx_Out=0 and read at 0x0000; effect2 is abandoned with no Done. Repeat with PREEMPT=0 -> effect0 waits for effect2's Done.
4. Request effect3 (LEN=0) -> Done pulse one cycle after grant, zero Rom_Rd_Out pulses, Busy_Out never high.
5. Override BASE[0]=0xFFFF, LEN[0]=2 -> reads at 0xFFFF then 0x0000. Assert Sfx_Stop_In together with a bit2 request mid-play -> IDLE next cycle, Signal=0, Pending_Out=0, no Done.
6. Drop Master_Reset_N_In mid-PLAY between clock edges -> all outputs 0 immediately (asynchronously). After release, the block stays idle until a new request arrives.
